// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: merges the single-cycle ALU writeback with
// FIFO-buffered load writebacks, with a starvation guard and a pending-load scoreboard.
module regfile_wb_arbiter #(
  parameter int LSU_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              alu_valid,
  output logic                              alu_ready,
  input  logic [4:0]                        alu_rd,
  input  logic [31:0]                       alu_data,
  input  logic                              lsu_valid,
  output logic                              lsu_ready,
  input  logic [4:0]                        lsu_rd,
  input  logic [31:0]                       lsu_data,
  output logic                              wb_we,
  output logic [4:0]                        wb_addr,
  output logic [31:0]                       wb_data,
  input  logic [4:0]                        q1_addr,
  input  logic [4:0]                        q2_addr,
  output logic                              q1_busy,
  output logic                              q2_busy,
  output logic [$clog2(LSU_FIFO_DEPTH):0]   fifo_count,
  output logic                              starve_active
);

  localparam int PTR_W = $clog2(LSU_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       mem_rd_q   [LSU_FIFO_DEPTH];
  logic [4:0]       mem_rd_d   [LSU_FIFO_DEPTH];
  logic [31:0]      mem_data_q [LSU_FIFO_DEPTH];
  logic [31:0]      mem_data_d [LSU_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SC_W-1:0]  starve_q, starve_d;
  logic             wb_we_q, wb_we_d;
  logic [4:0]       wb_addr_q, wb_addr_d;
  logic [31:0]      wb_data_q, wb_data_d;

  logic fifo_empty, force_b, push, pop, alu_gnt;

  assign fifo_empty    = (count_q == '0);
  assign force_b       = (starve_q == SC_W'(STARVE_LIMIT)) && !fifo_empty;
  assign starve_active = force_b;
  assign alu_ready     = !rst && !force_b;
  assign lsu_ready     = !rst && (count_q < CNT_W'(LSU_FIFO_DEPTH));
  assign push          = lsu_valid && lsu_ready;
  assign pop           = !rst && !fifo_empty && (force_b || !alu_valid);
  assign alu_gnt       = !rst && alu_valid && !force_b;

  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_rd_d[wr_ptr_q]   = lsu_rd;
      mem_data_d[wr_ptr_q] = lsu_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Counter only advances while the head is waiting; a pop or empty FIFO restarts it.
    if (fifo_empty || pop)                   starve_d = '0;
    else if (starve_q < SC_W'(STARVE_LIMIT)) starve_d = starve_q + SC_W'(1);
    else                                     starve_d = starve_q;

    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    if (pop) begin
      wb_we_d   = (mem_rd_q[rd_ptr_q] != 5'd0);
      wb_addr_d = mem_rd_q[rd_ptr_q];
      wb_data_d = mem_data_q[rd_ptr_q];
    end else if (alu_gnt) begin
      wb_we_d   = (alu_rd != 5'd0);
      wb_addr_d = alu_rd;
      wb_data_d = alu_data;
    end
  end

  // Scoreboard looks only at registered entries between rd_ptr and rd_ptr+count.
  always_comb begin
    logic [PTR_W-1:0] off;
    q1_busy = 1'b0;
    q2_busy = 1'b0;
    off     = '0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (mem_rd_q[i] == q1_addr) q1_busy = 1'b1;
        if (mem_rd_q[i] == q2_addr) q2_busy = 1'b1;
      end
    end
    q1_busy = q1_busy && (q1_addr != 5'd0);
    q2_busy = q2_busy && (q2_addr != 5'd0);
  end

  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_we      = wb_we_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, ALU path, LSU path, starvation, full FIFO,
// x0 writes and mid-operation reset, each with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  q1_addr, q2_addr;
  logic        q1_busy, q2_busy;
  logic [2:0]  fifo_count;
  logic        starve_active;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.LSU_FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_busy(q1_busy), .q2_busy(q2_busy),
    .fifo_count(fifo_count), .starve_active(starve_active)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
    q1_addr = 5'd0; q2_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %0h exp 0", alu_ready); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_lsu_ready: got %0h exp 0", lsu_ready); end
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %0h exp 0", wb_we); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", fifo_count); end
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %0h exp 1", alu_ready); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_lsu_ready: got %0h exp 1", lsu_ready); end
    checks++; if (wb_addr !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_regs: got %0d/%h exp 0/0", wb_addr, wb_data); end
  endtask

  task automatic test_alu();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0h exp 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 32'h00001234) begin errors++; $display("FAIL alu_wb: got we=%0h a=%0d d=%h exp 1/5/00001234", wb_we, wb_addr, wb_data); end
    step();
    checks++; if (wb_we !== 1'b0 || wb_data !== 32'h00001234) begin errors++; $display("FAIL alu_wb_drop: got we=%0h d=%h exp 0/00001234", wb_we, wb_data); end
  endtask

  task automatic test_lsu_single();
    idle_inputs();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD; q1_addr = 5'd7;
    #1;
    checks++; if (q1_busy !== 1'b0) begin errors++; $display("FAIL lsu_busy_same_cycle: got %0h exp 0", q1_busy); end
    step();
    lsu_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL lsu_count: got %0d exp 1", fifo_count); end
    checks++; if (q1_busy !== 1'b1) begin errors++; $display("FAIL lsu_busy: got %0h exp 1", q1_busy); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL lsu_no_bypass: got %0h exp 0", wb_we); end
    step();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd7 || wb_data !== 32'hDEAD) begin errors++; $display("FAIL lsu_wb: got we=%0h a=%0d d=%h exp 1/7/0000dead", wb_we, wb_addr, wb_data); end
    checks++; if (q1_busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL lsu_drained: got busy=%0h cnt=%0d exp 0/0", q1_busy, fifo_count); end
  endtask

  task automatic test_starve();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    step();
    lsu_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      alu_rd = 5'(20 + k); alu_data = 32'(20 + k);
      #1;
      checks++; if (starve_active !== 1'b0) begin errors++; $display("FAIL starve_early_%0d: got %0h exp 0", k, starve_active); end
      step();
      checks++; if (wb_addr !== 5'(20 + k)) begin errors++; $display("FAIL starve_alu_%0d: got %0d exp %0d", k, wb_addr, 20 + k); end
    end
    alu_rd = 5'd24; alu_data = 32'h24;
    #1;
    checks++; if (starve_active !== 1'b1 || alu_ready !== 1'b0) begin errors++; $display("FAIL starve_force: got sa=%0h ar=%0h exp 1/0", starve_active, alu_ready); end
    step();
    checks++; if (wb_we !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 32'h99) begin errors++; $display("FAIL starve_lsu_wb: got we=%0h a=%0d d=%h exp 1/9/00000099", wb_we, wb_addr, wb_data); end
    checks++; if (starve_active !== 1'b0 || alu_ready !== 1'b1) begin errors++; $display("FAIL starve_release: got sa=%0h ar=%0h exp 0/1", starve_active, alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wb_addr !== 5'd24 || wb_data !== 32'h24) begin errors++; $display("FAIL starve_alu_resume: got %0d/%h exp 24/00000024", wb_addr, wb_data); end
    step();
  endtask

  task automatic test_full();
    logic [4:0] exp_rd [4];
    logic [31:0] exp_d [4];
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'(k);
      lsu_valid = 1'b1; lsu_rd = 5'(1 + k); lsu_data = 32'hA1 + 32'(k);
      step();
    end
    alu_rd = 5'd30;
    lsu_rd = 5'd31; lsu_data = 32'hE;
    #1;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", fifo_count); end
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL full_lsu_ready: got %0h exp 0", lsu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wb_addr !== 5'd1 || wb_data !== 32'hA1 || fifo_count !== 3'd3) begin errors++; $display("FAIL full_pop0: got a=%0d d=%h cnt=%0d exp 1/000000a1/3", wb_addr, wb_data, fifo_count); end
    // Simultaneous push and pop: duplicate rd=2 enters as the last entry.
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hA5; q1_addr = 5'd2;
    step();
    lsu_valid = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL push_pop_count: got %0d exp 3", fifo_count); end
    checks++; if (q1_busy !== 1'b1) begin errors++; $display("FAIL dup_busy: got %0h exp 1", q1_busy); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL drain_ready: got %0h exp 1", lsu_ready); end
    exp_rd[0] = 5'd2; exp_d[0] = 32'hA2;
    exp_rd[1] = 5'd3; exp_d[1] = 32'hA3;
    exp_rd[2] = 5'd4; exp_d[2] = 32'hA4;
    exp_rd[3] = 5'd2; exp_d[3] = 32'hA5;
    checks++; if (wb_addr !== exp_rd[0] || wb_data !== exp_d[0]) begin errors++; $display("FAIL order_0: got %0d/%h exp %0d/%h", wb_addr, wb_data, exp_rd[0], exp_d[0]); end
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (wb_we !== 1'b1 || wb_addr !== exp_rd[k] || wb_data !== exp_d[k]) begin errors++; $display("FAIL order_%0d: got we=%0h %0d/%h exp 1/%0d/%h", k, wb_we, wb_addr, wb_data, exp_rd[k], exp_d[k]); end
    end
    checks++; if (fifo_count !== 3'd0 || q1_busy !== 1'b0) begin errors++; $display("FAIL full_drained: got cnt=%0d busy=%0h exp 0/0", fifo_count, q1_busy); end
    step();
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL full_no_fifth: got %0h exp 0", wb_we); end
  endtask

  task automatic test_x0();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready: got %0h exp 1", alu_ready); end
    step();
    alu_valid = 1'b0;
    checks++; if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL x0_alu_wb: got we=%0h a=%0d d=%h exp 0/0/ffffffff", wb_we, wb_addr, wb_data); end
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55; q1_addr = 5'd0;
    step();
    lsu_valid = 1'b0;
    checks++; if (fifo_count !== 3'd1 || q1_busy !== 1'b0) begin errors++; $display("FAIL x0_lsu_busy: got cnt=%0d busy=%0h exp 1/0", fifo_count, q1_busy); end
    step();
    checks++; if (wb_we !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL x0_lsu_wb: got we=%0h cnt=%0d exp 0/0", wb_we, fifo_count); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1; alu_rd = 5'd25; alu_data = 32'h25;
      lsu_valid = 1'b1; lsu_rd = 5'(11 + k); lsu_data = 32'hB0 + 32'(k);
      step();
    end
    alu_valid = 1'b0; lsu_valid = 1'b0; q1_addr = 5'd11; q2_addr = 5'd13;
    #1;
    checks++; if (fifo_count !== 3'd3 || q1_busy !== 1'b1 || q2_busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got cnt=%0d b1=%0h b2=%0h exp 3/1/1", fifo_count, q1_busy, q2_busy); end
    rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got ar=%0h lr=%0h exp 0/0", alu_ready, lsu_ready); end
    step();
    rst = 1'b0;
    checks++; if (fifo_count !== 3'd0 || wb_we !== 1'b0 || q1_busy !== 1'b0 || q2_busy !== 1'b0) begin errors++; $display("FAIL mid_post: got cnt=%0d we=%0h b1=%0h b2=%0h exp 0/0/0/0", fifo_count, wb_we, q1_busy, q2_busy); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mid_no_issue_%0d: got %0h exp 0", k, wb_we); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_lsu_single();
    test_starve();
    test_full();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
